// File: rtl/sa_c_drain_collector.sv
// Result-side collector for the PE array: requests one row-major drain per pe_done, buffers the
// tile in a first-word-fall-through FIFO and replays it on a valid/ready stream with a tile-last flag.
module sa_c_drain_collector #(
    parameter int SIDE       = 8,
    parameter int ACC_BITS   = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pe_done,
    output logic                c_drain_req,
    input  logic                c_busy,
    input  logic                c_valid,
    input  logic [ACC_BITS-1:0] c_data,
    input  logic                c_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [ACC_BITS-1:0] m_data,
    output logic                m_last,
    output logic                busy,
    input  logic                err_clr,
    output logic                err_frame,
    output logic                err_ovf
);
    localparam int TILE = SIDE * SIDE;
    localparam int WCW  = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    localparam logic [WCW-1:0]  LAST_IDX = WCW'(TILE - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] TILE_C   = CNTW'(TILE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV
    } state_t;

    state_t              r_state;
    logic                r_pend;
    logic [WCW-1:0]      r_word_cnt;
    logic                r_drain_req;
    logic                r_err_frame;
    logic                r_err_ovf;

    logic [ACC_BITS:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CNTW-1:0]     r_count;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_at_end;
    logic                w_push_last;
    logic [CNTW-1:0]     w_free;
    logic                w_start;
    logic                w_frame_set;
    logic                w_ovf_set;
    logic [ACC_BITS:0]   w_head;

    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == DEPTH_C);
        w_pop       = !w_empty && m_ready;
        w_push_req  = (r_state == S_RECV) && c_valid;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        w_push      = w_push_req && (!w_full || w_pop);
        w_at_end    = (r_word_cnt == LAST_IDX);
        w_push_last = c_last || w_at_end;
        w_free      = DEPTH_C - r_count;
        w_start     = (r_state == S_IDLE) && r_pend && (w_free >= TILE_C);
        w_frame_set = (c_valid && (r_state != S_RECV)) || (w_push_req && (c_last != w_at_end));
        w_ovf_set   = (pe_done && r_pend) || (w_push_req && w_full && !w_pop);
        w_head      = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_word_cnt  <= '0;
            r_drain_req <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_pend      <= w_start ? 1'b0 : (r_pend || pe_done);
            r_err_frame <= w_frame_set || (r_err_frame && !err_clr);
            r_err_ovf   <= w_ovf_set || (r_err_ovf && !err_clr);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_REQ;
                        r_drain_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (c_busy) begin
                        r_state     <= S_RECV;
                        r_drain_req <= 1'b0;
                        r_word_cnt  <= '0;
                    end
                end
                S_RECV: begin
                    if (c_valid) begin
                        if (w_push_last) begin
                            r_state    <= S_IDLE;
                            r_word_cnt <= '0;
                        end else begin
                            r_word_cnt <= r_word_cnt + WCW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_drain_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the count hides stale entries, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_push_last, c_data};
    end

    assign c_drain_req = r_drain_req;
    assign m_valid     = !w_empty;
    assign m_data      = w_empty ? '0 : w_head[ACC_BITS-1:0];
    assign m_last      = !w_empty && w_head[ACC_BITS];
    assign busy        = (r_state != S_IDLE) || r_pend;
    assign err_frame   = r_err_frame;
    assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_sa_c_drain_collector.sv
// Bench for sa_c_drain_collector: a behavioural PE-array drain model, a patterned/random sink
// and a tile-level queue model of the expected output stream.
`timescale 1ns/1ps
module tb_sa_c_drain_collector;
    localparam int SIDE       = 8;
    localparam int ACC_BITS   = 32;
    localparam int FIFO_DEPTH = 64;
    localparam int TILE       = SIDE * SIDE;

    logic                clk = 1'b0;
    logic                rst, pe_done, c_drain_req, c_busy, c_valid, c_last;
    logic                m_valid, m_ready, m_last, busy, err_clr, err_frame, err_ovf;
    logic [ACC_BITS-1:0] c_data, m_data;

    int n_checks = 0;
    int n_fail   = 0;

    int                  ready_mode, last_pos, arr_phase, arr_idx, drains, cyc, stall_bad, req_run;
    bit                  seed_zero, busy_probe, stall_prev;
    logic                busy_at_last, busy_after_last, stall_last;
    logic [ACC_BITS-1:0] cur_seed, stall_data;
    logic [ACC_BITS:0]   obs_q[$];
    logic [ACC_BITS:0]   exp_q[$];
    logic [ACC_BITS-1:0] seed_q[$];
    int                  req_runs[$];
    int                  req_rise_pops[$];

    always #5 clk = ~clk;

    sa_c_drain_collector #(
        .SIDE       (SIDE),
        .ACC_BITS   (ACC_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pe_done     (pe_done),
        .c_drain_req (c_drain_req),
        .c_busy      (c_busy),
        .c_valid     (c_valid),
        .c_data      (c_data),
        .c_last      (c_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .err_clr     (err_clr),
        .err_frame   (err_frame),
        .err_ovf     (err_ovf)
    );

    // Array drain engine and downstream sink, both acting mid-cycle on the falling edge.
    task automatic run_model();
        forever begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
            if (stall_prev && !(m_valid === 1'b1 && m_data === stall_data && m_last === stall_last))
                stall_bad++;
            if (m_valid === 1'b1 && m_ready) obs_q.push_back({m_last, m_data});
            stall_prev = (m_valid === 1'b1) && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (c_drain_req === 1'b1) begin
                if (req_run == 0) req_rise_pops.push_back(obs_q.size());
                req_run++;
            end else if (req_run != 0) begin
                req_runs.push_back(req_run);
                req_run = 0;
            end
            if (busy_probe) begin
                busy_after_last = busy;
                busy_probe      = 1'b0;
            end
            case (arr_phase)
                0: begin
                    if (c_drain_req === 1'b1) begin
                        arr_phase = 1;
                        drains++;
                        cur_seed = seed_zero ? '0 : ACC_BITS'($urandom);
                        seed_q.push_back(cur_seed);
                    end
                end
                1: begin
                    c_busy    = 1'b1;
                    arr_idx   = 0;
                    arr_phase = 2;
                end
                default: begin
                    if (arr_idx == TILE) begin
                        c_valid   = 1'b0;
                        c_last    = 1'b0;
                        c_data    = '0;
                        c_busy    = 1'b0;
                        arr_phase = 0;
                    end else begin
                        c_valid = 1'b1;
                        c_data  = cur_seed + ACC_BITS'(arr_idx);
                        c_last  = (arr_idx == last_pos);
                        if (arr_idx == TILE - 1) begin
                            busy_at_last = busy;
                            busy_probe   = 1'b1;
                        end
                        arr_idx++;
                    end
                end
            endcase
        end
    endtask

    // Expected words of one tile: stop at the first word flagged by the array or at word TILE-1.
    function automatic void add_tile(input logic [ACC_BITS-1:0] seed, input int lpos);
        logic lst;
        for (int i = 0; i < TILE; i++) begin
            lst = (i == lpos) || (i == TILE - 1);
            exp_q.push_back({lst, seed + ACC_BITS'(i)});
            if (lst) break;
        end
    endfunction

    function automatic int stream_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic clear_books();
        obs_q.delete();
        exp_q.delete();
        seed_q.delete();
        req_runs.delete();
        req_rise_pops.delete();
        drains    = 0;
        stall_bad = 0;
    endtask

    task automatic pulse_pe_done();
        @(negedge clk); pe_done = 1'b1;
        @(negedge clk); pe_done = 1'b0;
    endtask

    task automatic wait_quiet(input int max_cyc, input bit need_empty, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (arr_phase == 0 && busy === 1'b0 && (!need_empty || m_valid === 1'b0)) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (c_drain_req !== 1'b0) begin n_fail++; $display("FAIL reset_c_drain_req: got %b, expected 0", c_drain_req); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h, expected 0", m_data); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b, expected 0", m_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL reset_err_frame: got %b, expected 0", err_frame); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err_ovf: got %b, expected 0", err_ovf); end
    endtask

    task automatic test_single_tile();
        bit to;
        int d, first_run;
        clear_books();
        ready_mode = 0; last_pos = TILE - 1; seed_zero = 1'b1;
        pulse_pe_done();
        n_checks++; if (busy !== 1'b1 || c_drain_req !== 1'b0) begin n_fail++; $display("FAIL single_pend: busy=%b req=%b, expected busy=1 req=0", busy, c_drain_req); end
        @(negedge clk);
        n_checks++; if (c_drain_req !== 1'b1) begin n_fail++; $display("FAIL single_req_t2: got %b, expected 1", c_drain_req); end
        wait_quiet(300, 1'b1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout, expected completion"); end
        first_run = (req_runs.size() > 0) ? req_runs[0] : -1;
        n_checks++; if (req_runs.size() != 1 || first_run != 2) begin n_fail++; $display("FAIL single_req_len: got %0d requests first %0d cycles, expected 1 request of 2 cycles", req_runs.size(), first_run); end
        n_checks++; if (obs_q.size() != TILE) begin n_fail++; $display("FAIL single_count: got %0d words, expected %0d", obs_q.size(), TILE); end
        add_tile('0, TILE - 1);
        d = stream_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL single_stream: word %0d got %h expected %h", d, (d < obs_q.size()) ? obs_q[d] : 'x, (d < exp_q.size()) ? exp_q[d] : 'x); end
        n_checks++; if (busy_at_last !== 1'b1 || busy_after_last !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b/%b around c_last, expected 1/0", busy_at_last, busy_after_last); end
        n_checks++; if (err_frame !== 1'b0 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL single_errors: got frame=%b ovf=%b, expected 0/0", err_frame, err_ovf); end
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        clear_books();
        ready_mode = 1; seed_zero = 1'b0;
        pulse_pe_done();
        wait_quiet(500, 1'b1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: got timeout, expected completion"); end
        n_checks++; if (obs_q.size() != TILE) begin n_fail++; $display("FAIL bp_count: got %0d words, expected %0d", obs_q.size(), TILE); end
        if (seed_q.size() > 0) add_tile(seed_q[0], TILE - 1);
        d = stream_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL bp_stream: word %0d got %h expected %h", d, (d < obs_q.size()) ? obs_q[d] : 'x, (d < exp_q.size()) ? exp_q[d] : 'x); end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles, expected 0", stall_bad); end
        n_checks++; if (err_frame !== 1'b0 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_errors: got frame=%b ovf=%b, expected 0/0", err_frame, err_ovf); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d, rise;
        clear_books();
        ready_mode = 3; seed_zero = 1'b0;
        pulse_pe_done();
        wait_quiet(300, 1'b0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_fill_timeout: got timeout, expected first tile buffered"); end
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_held: got m_valid=%b, expected 1", m_valid); end
        pulse_pe_done();
        repeat (20) @(negedge clk);
        n_checks++; if (c_drain_req !== 1'b0 || req_rise_pops.size() != 1) begin n_fail++; $display("FAIL b2b_req_held: got req=%b requests=%0d, expected 0/1", c_drain_req, req_rise_pops.size()); end
        ready_mode = 0;
        wait_quiet(800, 1'b1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got timeout, expected completion"); end
        rise = (req_rise_pops.size() == 2) ? req_rise_pops[1] : -1;
        n_checks++; if (rise < TILE) begin n_fail++; $display("FAIL b2b_req_after_pops: got %0d pops before second request, expected >= %0d", rise, TILE); end
        n_checks++; if (obs_q.size() != 2 * TILE) begin n_fail++; $display("FAIL b2b_count: got %0d words, expected %0d", obs_q.size(), 2 * TILE); end
        foreach (seed_q[i]) add_tile(seed_q[i], TILE - 1);
        d = stream_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL b2b_stream: word %0d got %h expected %h", d, (d < obs_q.size()) ? obs_q[d] : 'x, (d < exp_q.size()) ? exp_q[d] : 'x); end
        n_checks++; if (err_frame !== 1'b0 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_errors: got frame=%b ovf=%b, expected 0/0", err_frame, err_ovf); end
    endtask

    task automatic test_framing();
        bit to;
        int d;
        clear_books();
        ready_mode = 2; seed_zero = 1'b0; last_pos = 10;
        pulse_pe_done();
        wait_quiet(400, 1'b1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL frame_timeout: got timeout, expected completion"); end
        n_checks++; if (err_frame !== 1'b1) begin n_fail++; $display("FAIL frame_err: got %b, expected 1", err_frame); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL frame_ovf: got %b, expected 0", err_ovf); end
        n_checks++; if (obs_q.size() != 11) begin n_fail++; $display("FAIL frame_count: got %0d words, expected 11", obs_q.size()); end
        if (seed_q.size() > 0) add_tile(seed_q[0], 10);
        d = stream_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL frame_stream: word %0d got %h expected %h", d, (d < obs_q.size()) ? obs_q[d] : 'x, (d < exp_q.size()) ? exp_q[d] : 'x); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL frame_clear: got %b, expected 0", err_frame); end
        last_pos = TILE - 1;
    endtask

    task automatic test_lost_request();
        bit to;
        int d;
        clear_books();
        ready_mode = 2; seed_zero = 1'b0;
        pulse_pe_done();
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arr_phase == 2 && arr_idx >= 5) begin to = 1'b0; break; end
        end
        n_checks++; if (to) begin n_fail++; $display("FAIL lost_recv_timeout: got timeout, expected drain start"); end
        pulse_pe_done();
        @(negedge clk);
        pulse_pe_done();
        @(negedge clk); pe_done = 1'b1; err_clr = 1'b1;
        @(negedge clk); pe_done = 1'b0; err_clr = 1'b0;
        n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL lost_set_wins: got %b, expected 1", err_ovf); end
        wait_quiet(1000, 1'b1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL lost_timeout: got timeout, expected completion"); end
        n_checks++; if (drains != 2) begin n_fail++; $display("FAIL lost_drains: got %0d drains, expected 2", drains); end
        n_checks++; if (err_ovf !== 1'b1 || err_frame !== 1'b0) begin n_fail++; $display("FAIL lost_errors: got ovf=%b frame=%b, expected 1/0", err_ovf, err_frame); end
        n_checks++; if (obs_q.size() != 2 * TILE) begin n_fail++; $display("FAIL lost_count: got %0d words, expected %0d", obs_q.size(), 2 * TILE); end
        foreach (seed_q[i]) add_tile(seed_q[i], TILE - 1);
        d = stream_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL lost_stream: word %0d got %h expected %h", d, (d < obs_q.size()) ? obs_q[d] : 'x, (d < exp_q.size()) ? exp_q[d] : 'x); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL lost_clear: got %b, expected 0", err_ovf); end
    endtask

    task automatic test_reset_mid_recv();
        bit to;
        clear_books();
        ready_mode = 3; seed_zero = 1'b0;
        pulse_pe_done();
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arr_phase == 2 && arr_idx >= 21) begin to = 1'b0; break; end
        end
        n_checks++; if (to || m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: timeout=%b m_valid=%b, expected 0/1", to, m_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (m_valid !== 1'b0 || m_data !== '0) begin n_fail++; $display("FAIL rstmid_flush: got m_valid=%b m_data=%h, expected 0/0", m_valid, m_data); end
        n_checks++; if (busy !== 1'b0 || c_drain_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b req=%b, expected 0/0", busy, c_drain_req); end
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arr_phase == 0) begin to = 1'b0; break; end
        end
        @(negedge clk);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_tail_timeout: got timeout, expected array drain end"); end
        n_checks++; if (err_frame !== 1'b1) begin n_fail++; $display("FAIL rstmid_err_frame: got %b, expected 1", err_frame); end
        n_checks++; if (m_valid !== 1'b0 || obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_dropped: got m_valid=%b words=%0d, expected 0/0", m_valid, obs_q.size()); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b, expected 0", err_ovf); end
    endtask

    initial begin
        rst = 1'b1; pe_done = 1'b0; err_clr = 1'b0; m_ready = 1'b0;
        c_busy = 1'b0; c_valid = 1'b0; c_last = 1'b0; c_data = '0;
        ready_mode = 0; last_pos = TILE - 1; arr_phase = 0; arr_idx = 0;
        drains = 0; cyc = 0; stall_bad = 0; req_run = 0;
        seed_zero = 1'b0; busy_probe = 1'b0; stall_prev = 1'b0;
        busy_at_last = 1'b0; busy_after_last = 1'b0; stall_last = 1'b0;
        cur_seed = '0; stall_data = '0;
        fork
            run_model();
        join_none
        test_reset();
        test_single_tile();
        test_backpressure();
        test_back_to_back();
        test_framing();
        test_lost_request();
        test_reset_mid_recv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
